tx_resp_packer: RTL

- Response framer between the system controller's response sources and the TX async FIFO write port, in the REF_CLK domain.
- Accepts register-read bytes and 16-bit ALU results and buffers them in a small entry queue.
- Serialises each entry into a byte frame (optional header, then payload) and writes it into the FIFO one byte per cycle, stalling on FIFO full.
- Ensures no response byte is lost to back-pressure while the UART TX drains slowly.

---
 rtl/tx_resp_packer_if.sv | 27 ++
 rtl/tx_resp_packer.sv | 110 +++++++++++
 2 files changed

// File: rtl/tx_resp_packer_if.sv
// Response-packer bus: response sources in, TX FIFO write port and status out.
interface tx_resp_packer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_valid;
  logic                    fifo_full;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    fifo_wr_inc;
  logic                    q_full;
  logic                    q_empty;
  logic                    overflow;

  // Upstream side: response sources plus the FIFO full flag.
  modport master (
    output rd_data, rd_valid, alu_out, alu_valid, fifo_full,
    input  fifo_wr_data, fifo_wr_inc, q_full, q_empty, overflow
  );

  // Packer side.
  modport slave (
    input  rd_data, rd_valid, alu_out, alu_valid, fifo_full,
    output fifo_wr_data, fifo_wr_inc, q_full, q_empty, overflow
  );
endinterface

// File: rtl/tx_resp_packer.sv
// Response framer: queues register-read bytes and ALU results, then writes
// each as a byte frame (optional header, payload low byte first) into the
// TX async FIFO, stalling while the FIFO reports full.
module tx_resp_packer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter bit                    HDR_EN     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] HDR_RD     = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] HDR_ALU    = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  tx_resp_packer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_B0, S_B1} state_t;

  state_t                  state_q;
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q;
  logic                    overflow_q;

  logic                    typ_mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] pay_mem [DEPTH];
  logic                    type_q;
  logic [2*DATA_WIDTH-1:0] frame_q;

  logic                    wr_inc, last_byte, pop;
  logic                    has1, has2, wr_alu, wr_rd, drop;
  logic [PW-1:0]           rd_slot;
  logic [DATA_WIDTH-1:0]   wr_data;
  state_t                  first_st;

  // Write strobe, frame end detection, pop and enqueue admission decisions.
  always_comb begin
    wr_inc    = (state_q != S_IDLE) && !bus.fifo_full;
    last_byte = (state_q == S_B1) || ((state_q == S_B0) && !type_q);
    pop       = (count_q != '0) && ((state_q == S_IDLE) || (wr_inc && last_byte));
    first_st  = HDR_EN ? S_HDR : S_B0;
    // A slot vacated by this edge's pop is usable by this edge's write.
    has1      = (count_q < DEPTH_C) || pop;
    has2      = (count_q < DEPTH_M1) || (pop && (count_q == DEPTH_M1));
    wr_alu    = bus.alu_valid && has1;
    wr_rd     = bus.rd_valid && (bus.alu_valid ? has2 : has1);
    drop      = (bus.alu_valid && !has1) || (bus.rd_valid && !wr_rd);
    rd_slot   = wr_alu ? (wptr_q + PW'(1)) : wptr_q;
  end

  // Byte selection from the frame register; zero while idle.
  always_comb begin
    wr_data = '0;
    case (state_q)
      S_HDR:   wr_data = type_q ? HDR_ALU : HDR_RD;
      S_B0:    wr_data = frame_q[DATA_WIDTH-1:0];
      S_B1:    wr_data = frame_q[2*DATA_WIDTH-1:DATA_WIDTH];
      default: wr_data = '0;
    endcase
  end

  // Entry storage and frame register load; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_alu) begin
      typ_mem[wptr_q] <= 1'b1;
      pay_mem[wptr_q] <= bus.alu_out;
    end
    if (wr_rd) begin
      typ_mem[rd_slot] <= 1'b0;
      pay_mem[rd_slot] <= {{DATA_WIDTH{1'b0}}, bus.rd_data};
    end
    if (pop) begin
      type_q  <= typ_mem[rptr_q];
      frame_q <= pay_mem[rptr_q];
    end
  end

  // Queue pointers, occupancy, overflow flag and emitter state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_q + PW'(wr_alu) + PW'(wr_rd);
      rptr_q     <= rptr_q + PW'(pop);
      count_q    <= count_q + CW'(wr_alu) + CW'(wr_rd) - CW'(pop);
      overflow_q <= drop;
      if (pop) begin
        state_q <= first_st;
      end else if (wr_inc) begin
        case (state_q)
          S_HDR:   state_q <= S_B0;
          S_B0:    state_q <= type_q ? S_B1 : S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_wr_inc  = wr_inc;
  assign bus.fifo_wr_data = wr_data;
  assign bus.q_full       = (count_q == DEPTH_C);
  assign bus.q_empty      = (count_q == '0) && (state_q == S_IDLE);
  assign bus.overflow     = overflow_q;
endmodule
